// File: rtl/ahblite_arb_pkg.sv
// Purpose: shared types and helpers for the AHB-Lite per-slave arbiter.
// Contents: arbiter state enum, arbitration-mode constants, index-width helper.
package ahblite_arb_pkg;

  // Arbiter state: plain arbitration, wait-state hold, locked sequence, locked wait-state hold
  typedef enum logic [1:0] {
    ARB       = 2'd0,
    HOLD      = 2'd1,
    LOCK      = 2'd2,
    LOCK_HOLD = 2'd3
  } arb_state_e;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Width of a master index; never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahblite_rr_pick.sv
// Purpose: combinational find-first-set over N request bits, starting at
//   start_i and wrapping from N-1 back to 0.
// Ports:
//   req_i    in  N      request vector
//   start_i  in  IDX_W  first index to examine (must be < N)
//   found_o  out 1      some request bit is set
//   idx_o    out IDX_W  first set index at or after start_i (wrapping); 0 if none
module ahblite_rr_pick
  import ahblite_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest hit to start_i overwrites the others
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(start_i) + i) % int'(N));
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ahblite_slave_arbiter_param.sv
// Purpose: per-slave AHB-Lite arbiter. Picks one requesting master per address
//   phase, holds the grant through wait states and across HMASTLOCK sequences.
//   Round-robin or fixed priority with a starvation guard.
// Ports:
//   HCLK, HRESETN  clock, synchronous active-low reset
//   req            per-master request (valid HTRANS + decode hit)
//   lock           per-master HMASTLOCK
//   hready         slave-port HREADY (data phase completes)
//   grant          one-hot grant, combinational
//   grant_valid    |grant
//   grant_idx      granted master index, 0 when no grant
//   locked         arbiter is in a locked sequence
module ahblite_slave_arbiter_param
  import ahblite_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ARB_MODE    = MODE_RR,
  parameter int unsigned BURST_LIMIT = 8
) (
  input  logic                               HCLK,
  input  logic                               HRESETN,
  input  logic [NUM_MASTERS-1:0]             req,
  input  logic [NUM_MASTERS-1:0]             lock,
  input  logic                               hready,
  output logic [NUM_MASTERS-1:0]             grant,
  output logic                               grant_valid,
  output logic [idx_w(NUM_MASTERS)-1:0]      grant_idx,
  output logic                               locked
);

  localparam int unsigned IDX_W = idx_w(NUM_MASTERS);
  // Must hold both 1 and BURST_LIMIT
  localparam int unsigned CNT_W = $clog2(BURST_LIMIT + 2);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       win_cnt_q, win_cnt_d;

  logic [NUM_MASTERS-1:0] owner_oh, pick_oh, grant_c;
  logic [IDX_W-1:0]       owner_nxt, pick_start, pick_idx, gidx_c;
  logic                   pick_found, starve;

  assign owner_oh  = ONE_HOT0 << owner_q;
  assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  // Starvation guard: owner has used its burst and someone else is waiting
  assign starve = (ARB_MODE == MODE_FIXED) && (BURST_LIMIT != 0) &&
                  (win_cnt_q == CNT_W'(BURST_LIMIT)) && (|(req & ~owner_oh));

  assign pick_start = ((ARB_MODE == MODE_RR) || starve) ? owner_nxt : '0;

  ahblite_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign pick_oh = ONE_HOT0 << pick_idx;

  // Next-state, owner/win-count update and Mealy grant
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    win_cnt_d = win_cnt_q;
    grant_c   = '0;
    gidx_c    = owner_q;
    case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_c = pick_oh;
          gidx_c  = pick_idx;
          owner_d = pick_idx;
          if (lock[pick_idx]) begin
            state_d = hready ? LOCK : LOCK_HOLD;
          end else begin
            state_d = hready ? ARB : HOLD;
            if (starve) begin
              win_cnt_d = '0;
            end else if (pick_idx != owner_q) begin
              win_cnt_d = CNT_W'(1);
            end else if (win_cnt_q < CNT_W'(BURST_LIMIT)) begin
              win_cnt_d = win_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      HOLD: begin
        grant_c = owner_oh;
        if (hready) state_d = ARB;
      end
      LOCK: begin
        // Dropping lock costs one dead cycle before re-arbitration
        if (!lock[owner_q]) begin
          state_d = ARB;
        end else if (req[owner_q]) begin
          grant_c = owner_oh;
          state_d = hready ? LOCK : LOCK_HOLD;
        end
      end
      LOCK_HOLD: begin
        grant_c = owner_oh;
        if (hready) state_d = LOCK;
      end
      default: state_d = ARB;
    endcase
  end

  // State registers
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q   <= ARB;
      owner_q   <= LAST_IDX;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  // Outputs are forced idle while reset is held
  assign grant       = HRESETN ? grant_c : '0;
  assign grant_valid = |grant;
  assign grant_idx   = grant_valid ? gidx_c : '0;
  assign locked      = HRESETN && ((state_q == LOCK) || (state_q == LOCK_HOLD));

endmodule

// File: tb/tb_ahblite_slave_arbiter_param.sv
// Directed bench: round-robin, wait-state hold, locked sequences, fixed priority
// with and without the starvation guard, reset during a locked hold, 16 masters.
module tb_ahblite_slave_arbiter_param;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req, lock;
  logic        hready;
  logic [15:0] req16, lock16;

  logic [3:0]  g_rr,  g_f2,  g_f0;
  logic        gv_rr, gv_f2, gv_f0;
  logic [1:0]  gi_rr, gi_f2, gi_f0;
  logic        lk_rr, lk_f2, lk_f0;
  logic [15:0] g16;
  logic        gv16, lk16;
  logic [3:0]  gi16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahblite_slave_arbiter_param #(.NUM_MASTERS(4), .ARB_MODE(0), .BURST_LIMIT(8)) u_rr (
    .HCLK(clk), .HRESETN(rstn), .req(req), .lock(lock), .hready(hready),
    .grant(g_rr), .grant_valid(gv_rr), .grant_idx(gi_rr), .locked(lk_rr));

  ahblite_slave_arbiter_param #(.NUM_MASTERS(4), .ARB_MODE(1), .BURST_LIMIT(2)) u_f2 (
    .HCLK(clk), .HRESETN(rstn), .req(req), .lock(lock), .hready(hready),
    .grant(g_f2), .grant_valid(gv_f2), .grant_idx(gi_f2), .locked(lk_f2));

  ahblite_slave_arbiter_param #(.NUM_MASTERS(4), .ARB_MODE(1), .BURST_LIMIT(0)) u_f0 (
    .HCLK(clk), .HRESETN(rstn), .req(req), .lock(lock), .hready(hready),
    .grant(g_f0), .grant_valid(gv_f0), .grant_idx(gi_f0), .locked(lk_f0));

  ahblite_slave_arbiter_param #(.NUM_MASTERS(16), .ARB_MODE(0), .BURST_LIMIT(8)) u_rr16 (
    .HCLK(clk), .HRESETN(rstn), .req(req16), .lock(lock16), .hready(hready),
    .grant(g16), .grant_valid(gv16), .grant_idx(gi16), .locked(lk16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait until mid-cycle so combinational outputs have settled
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req    = '0;
    lock   = '0;
    req16  = '0;
    lock16 = '0;
    hready = 1'b1;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  int exp1  [5] = '{0, 1, 2, 3, 0};
  int exp4  [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    rstn   = 1'b0;
    req    = '0;
    lock   = '0;
    req16  = '0;
    lock16 = '0;
    hready = 1'b1;
    next_cycle();

    // Outputs idle while reset is held even with requests present
    req = 4'b1111;
    settle();
    check("rst_grant_low", 32'(g_rr), 32'h0);
    check("rst_gv_low",    32'(gv_rr), 32'h0);
    check("rst_idx_low",   32'(gi_rr), 32'h0);

    // Reset state, no requests
    do_reset();
    settle();
    check("idle_grant",  32'(g_rr),  32'h0);
    check("idle_locked", 32'(lk_rr), 32'h0);

    // 1: round-robin rotation, all masters requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("rr_idx%0d", i), 32'(gi_rr), 32'(exp1[i]));
      check($sformatf("rr_gnt%0d", i), 32'(g_rr), 32'(4'b0001 << exp1[i]));
      next_cycle();
    end

    // 2: wait-state hold ignores request changes
    do_reset();
    req    = 4'b0100;
    hready = 1'b0;
    settle();
    check("hold_first", 32'(g_rr), 32'h4);
    next_cycle();
    req = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("hold_wait%0d", i), 32'(g_rr), 32'h4);
      next_cycle();
    end
    hready = 1'b1;
    settle();
    check("hold_complete", 32'(g_rr), 32'h4);
    next_cycle();
    settle();
    check("hold_after", 32'(g_rr), 32'h1);
    next_cycle();

    // 3: locked sequence for master 1, master 0 blocked
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    settle();
    check("lock_beat0", 32'(g_rr), 32'h2);
    next_cycle();
    req = 4'b0011;
    for (int i = 1; i < 4; i++) begin
      settle();
      check($sformatf("lock_beat%0d", i), 32'(g_rr), 32'h2);
      check($sformatf("lock_lk%0d", i), 32'(lk_rr), 32'h1);
      next_cycle();
    end
    req = 4'b0001;
    settle();
    check("lock_idle_gnt", 32'(g_rr), 32'h0);
    check("lock_idle_lk",  32'(lk_rr), 32'h1);
    next_cycle();
    lock = 4'b0000;
    settle();
    check("lock_drop_dead", 32'(g_rr), 32'h0);
    next_cycle();
    settle();
    check("lock_after",    32'(g_rr), 32'h1);
    check("lock_after_lk", 32'(lk_rr), 32'h0);
    next_cycle();

    // 4/5: fixed priority with guard (limit 2) and without (limit 0)
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("fix2_idx%0d", i), 32'(gi_f2), 32'(exp4[i]));
      check($sformatf("fix0_idx%0d", i), 32'(gi_f0), 32'h0);
      check($sformatf("fix0_gv%0d", i),  32'(gv_f0), 32'h1);
      next_cycle();
    end

    // 6: reset during a locked wait-state hold
    do_reset();
    req    = 4'b0010;
    lock   = 4'b0010;
    hready = 1'b0;
    settle();
    check("rlk_arb", 32'(g_rr), 32'h2);
    next_cycle();
    settle();
    check("rlk_hold_gnt", 32'(g_rr), 32'h2);
    check("rlk_hold_lk",  32'(lk_rr), 32'h1);
    next_cycle();
    rstn = 1'b0;
    settle();
    check("rlk_rst_gnt", 32'(g_rr),  32'h0);
    check("rlk_rst_gv",  32'(gv_rr), 32'h0);
    check("rlk_rst_lk",  32'(lk_rr), 32'h0);
    next_cycle();
    rstn   = 1'b1;
    req    = 4'b1111;
    lock   = 4'b0000;
    hready = 1'b1;
    settle();
    check("rlk_after_gnt", 32'(g_rr),  32'h1);
    check("rlk_after_lk",  32'(lk_rr), 32'h0);
    next_cycle();

    // 16-master round-robin, wrapping 15 -> 0
    do_reset();
    req16 = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      settle();
      check($sformatf("rr16_idx%0d", i), 32'(gi16), 32'(i % 16));
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
